// File: rtl/alu_issue_queue_if.sv
// Command handshake bundle feeding the ALU issue queue.
// The producer drives the master side and the queue sits on the slave side.
interface alu_issue_queue_if #(
    parameter int TAG_W = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [7:0]       cmd_a;
    logic [7:0]       cmd_b;
    logic [2:0]       cmd_op;
    logic [TAG_W-1:0] cmd_tag;

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_op, cmd_tag,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_op, cmd_tag,
        output cmd_ready
    );
endinterface

// File: rtl/alu_issue_queue.sv
// Buffers ALU commands in a small FIFO, issues one per unstalled cycle and
// carries each issued tag alongside the ALU latency; screens illegal opcodes.
module alu_issue_queue #(
    parameter int DEPTH   = 4,
    parameter int LATENCY = 1,
    parameter int TAG_W   = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    alu_issue_queue_if.slave           cmd,
    input  logic                       stall_i,
    output logic                       alu_en_o,
    output logic [7:0]                 alu_a_o,
    output logic [7:0]                 alu_b_o,
    output logic [2:0]                 alu_op_o,
    output logic                       res_valid_o,
    output logic [TAG_W-1:0]           res_tag_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic [7:0]                 illegal_cnt_o,
    output logic                       illegal_seen_o
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [7:0]       memA [DEPTH];
    logic [7:0]       memB [DEPTH];
    logic [2:0]       memOp [DEPTH];
    logic [TAG_W-1:0] memTag [DEPTH];

    logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic [7:0]       illegal_cnt_q, illegal_cnt_d;
    logic             illegal_seen_q, illegal_seen_d;
    logic             alu_en_q;
    logic [7:0]       alu_a_q, alu_b_q;
    logic [2:0]       alu_op_q;
    logic [TAG_W-1:0] alu_tag_q;
    logic [LATENCY-1:0] pipe_v_q;
    logic [TAG_W-1:0] pipe_tag_q [LATENCY];

    logic accept, legal, push, pop;

    assign cmd.cmd_ready = (count_q < CW'(DEPTH));
    assign accept        = cmd.cmd_valid & cmd.cmd_ready;
    assign legal         = (cmd.cmd_op <= 3'd5);
    assign push          = accept & legal;
    assign pop           = (count_q != '0) & ~stall_i;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        head_d         = pop  ? head_q + PW'(1) : head_q;
        tail_d         = push ? tail_q + PW'(1) : tail_q;
        count_d        = count_q;
        illegal_cnt_d  = illegal_cnt_q;
        illegal_seen_d = illegal_seen_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
        if (accept && !legal) begin
            illegal_seen_d = 1'b1;
            if (illegal_cnt_q != 8'hFF) begin
                illegal_cnt_d = illegal_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            memA[tail_q]   <= cmd.cmd_a;
            memB[tail_q]   <= cmd.cmd_b;
            memOp[tail_q]  <= cmd.cmd_op;
            memTag[tail_q] <= cmd.cmd_tag;
        end
    end

    // Issue registers hold their operands between issues; only en drops.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            illegal_cnt_q  <= '0;
            illegal_seen_q <= 1'b0;
            alu_en_q       <= 1'b0;
            alu_a_q        <= '0;
            alu_b_q        <= '0;
            alu_op_q       <= '0;
            alu_tag_q      <= '0;
        end else begin
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            illegal_cnt_q  <= illegal_cnt_d;
            illegal_seen_q <= illegal_seen_d;
            alu_en_q       <= pop;
            if (pop) begin
                alu_a_q   <= memA[head_q];
                alu_b_q   <= memB[head_q];
                alu_op_q  <= memOp[head_q];
                alu_tag_q <= memTag[head_q];
            end
        end
    end

    // Tag shadow of the ALU pipeline; ignores stall so results keep flowing.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pipe_v_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                pipe_tag_q[i] <= '0;
            end
        end else begin
            pipe_v_q[0]   <= alu_en_q;
            pipe_tag_q[0] <= alu_en_q ? alu_tag_q : '0;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_v_q[i]   <= pipe_v_q[i-1];
                pipe_tag_q[i] <= pipe_tag_q[i-1];
            end
        end
    end

    assign alu_en_o       = alu_en_q;
    assign alu_a_o        = alu_a_q;
    assign alu_b_o        = alu_b_q;
    assign alu_op_o       = alu_op_q;
    assign res_valid_o    = pipe_v_q[LATENCY-1];
    assign res_tag_o      = pipe_tag_q[LATENCY-1];
    assign count_o        = count_q;
    assign illegal_cnt_o  = illegal_cnt_q;
    assign illegal_seen_o = illegal_seen_q;
endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed bench for alu_issue_queue: hand-computed expectations checked with
// immediate assertions one clock step at a time.
module tb_alu_issue_queue;
    localparam int DEPTH   = 4;
    localparam int LATENCY = 1;
    localparam int TAG_W   = 4;

    logic             clk;
    logic             rstN;
    logic             stall;
    logic             aluEn;
    logic [7:0]       aluA;
    logic [7:0]       aluB;
    logic [2:0]       aluOp;
    logic             resValid;
    logic [TAG_W-1:0] resTag;
    logic [2:0]       count;
    logic [7:0]       illegalCnt;
    logic             illegalSeen;

    int total = 0;
    int bad   = 0;

    alu_issue_queue_if #(.TAG_W(TAG_W)) ifc ();

    alu_issue_queue #(
        .DEPTH(DEPTH),
        .LATENCY(LATENCY),
        .TAG_W(TAG_W)
    ) dut (
        .clk_i(clk),
        .rst_ni(rstN),
        .cmd(ifc.slave),
        .stall_i(stall),
        .alu_en_o(aluEn),
        .alu_a_o(aluA),
        .alu_b_o(aluB),
        .alu_op_o(aluOp),
        .res_valid_o(resValid),
        .res_tag_o(resTag),
        .count_o(count),
        .illegal_cnt_o(illegalCnt),
        .illegal_seen_o(illegalSeen)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic [7:0] a, input logic [7:0] b,
                                 input logic [2:0] op, input logic [TAG_W-1:0] tag);
        ifc.cmd_valid = valid;
        ifc.cmd_a     = a;
        ifc.cmd_b     = b;
        ifc.cmd_op    = op;
        ifc.cmd_tag   = tag;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", name, observed, expected);
        end
    endtask

    initial begin
        rstN  = 1'b0;
        stall = 1'b0;
        applyStimulus(1'b0, 8'd0, 8'd0, 3'd0, 4'd0);
        tick();
        tick();
        rstN = 1'b1;

        $display("[TB] reset state");
        checkOutput("rst_alu_en", aluEn, 0);
        checkOutput("rst_res_valid", resValid, 0);
        checkOutput("rst_res_tag", resTag, 0);
        checkOutput("rst_count", count, 0);
        checkOutput("rst_ready", ifc.cmd_ready, 1);
        checkOutput("rst_illegal_cnt", illegalCnt, 0);
        checkOutput("rst_illegal_seen", illegalSeen, 0);
        checkOutput("rst_alu_a", aluA, 0);

        $display("[TB] single ADD");
        applyStimulus(1'b1, 8'd20, 8'd22, 3'd0, 4'd3);
        tick();
        applyStimulus(1'b0, 8'd0, 8'd0, 3'd0, 4'd0);
        checkOutput("add_count_after_accept", count, 1);
        checkOutput("add_no_bypass", aluEn, 0);
        tick();
        checkOutput("add_alu_en", aluEn, 1);
        checkOutput("add_alu_a", aluA, 20);
        checkOutput("add_alu_b", aluB, 22);
        checkOutput("add_alu_op", aluOp, 0);
        checkOutput("add_count_after_issue", count, 0);
        checkOutput("add_res_not_yet", resValid, 0);
        tick();
        checkOutput("add_en_drops", aluEn, 0);
        checkOutput("add_res_valid", resValid, 1);
        checkOutput("add_res_tag", resTag, 3);
        checkOutput("add_alu_a_hold", aluA, 20);
        tick();
        checkOutput("add_res_clear", resValid, 0);
        checkOutput("add_res_tag_zero", resTag, 0);

        $display("[TB] fill under stall");
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 8'(i), 8'd0, 3'd0, 4'(i));
            checkOutput("fill_ready", ifc.cmd_ready, 1);
            tick();
            checkOutput("fill_count", count, i + 1);
            checkOutput("fill_no_issue", aluEn, 0);
        end
        checkOutput("full_ready_low", ifc.cmd_ready, 0);
        applyStimulus(1'b1, 8'd4, 8'd0, 3'd0, 4'd4);
        tick();
        checkOutput("full_count_held", count, 4);
        stall = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (k == 1) applyStimulus(1'b0, 8'd0, 8'd0, 3'd0, 4'd0);
            checkOutput("drain_en", aluEn, 1);
            checkOutput("drain_a", aluA, k);
            if (k > 0) begin
                checkOutput("drain_res_valid", resValid, 1);
                checkOutput("drain_res_tag", resTag, k - 1);
            end
        end
        tick();
        checkOutput("drain_done_en", aluEn, 0);
        checkOutput("drain_last_tag", resTag, 4);
        checkOutput("drain_count", count, 0);

        $display("[TB] streaming through full queue");
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 8'(i), 8'd7, 3'd2, 4'(i));
            tick();
        end
        stall = 1'b0;
        for (int c = 0; c < 16; c++) begin
            if (c <= 12) begin
                applyStimulus(1'b1, (c == 0) ? 8'd4 : 8'(c + 3), 8'd7, 3'd2,
                              (c == 0) ? 4'd4 : 4'(c + 3));
            end else begin
                applyStimulus(1'b0, 8'd0, 8'd0, 3'd0, 4'd0);
            end
            tick();
            checkOutput("stream_en", aluEn, 1);
            checkOutput("stream_a", aluA, c);
            checkOutput("stream_count", count, (c <= 12) ? 3 : 15 - c);
            if (c > 0) checkOutput("stream_res_tag", resTag, c - 1);
        end
        tick();
        checkOutput("stream_end_en", aluEn, 0);
        checkOutput("stream_last_tag", resTag, 15);
        checkOutput("stream_op", aluOp, 2);

        $display("[TB] illegal opcodes");
        applyStimulus(1'b1, 8'd1, 8'd1, 3'd6, 4'd1);
        tick();
        checkOutput("ill6_cnt", illegalCnt, 1);
        checkOutput("ill6_seen", illegalSeen, 1);
        checkOutput("ill6_count", count, 0);
        applyStimulus(1'b1, 8'd1, 8'd1, 3'd7, 4'd2);
        tick();
        checkOutput("ill7_cnt", illegalCnt, 2);
        checkOutput("ill7_count", count, 0);
        checkOutput("ill7_no_en", aluEn, 0);
        applyStimulus(1'b1, 8'd255, 8'd255, 3'd1, 4'd9);
        tick();
        applyStimulus(1'b0, 8'd0, 8'd0, 3'd0, 4'd0);
        checkOutput("mul_count", count, 1);
        checkOutput("mul_cnt_unchanged", illegalCnt, 2);
        checkOutput("ill_never_issued", aluEn, 0);
        tick();
        checkOutput("mul_en", aluEn, 1);
        checkOutput("mul_op", aluOp, 1);
        checkOutput("mul_a", aluA, 255);
        checkOutput("mul_b", aluB, 255);
        tick();
        checkOutput("mul_res_tag", resTag, 9);
        applyStimulus(1'b1, 8'd0, 8'd0, 3'd7, 4'd0);
        for (int i = 0; i < 253; i++) tick();
        checkOutput("sat_reach", illegalCnt, 255);
        for (int i = 0; i < 47; i++) tick();
        checkOutput("sat_hold", illegalCnt, 255);
        checkOutput("sat_count", count, 0);
        checkOutput("sat_no_en", aluEn, 0);
        applyStimulus(1'b0, 8'd0, 8'd0, 3'd0, 4'd0);

        $display("[TB] toggling stall");
        stall = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(1'b1, 8'(50 + i), 8'd0, 3'd3, 4'(i));
            tick();
        end
        applyStimulus(1'b0, 8'd0, 8'd0, 3'd0, 4'd0);
        checkOutput("tog_count", count, 3);
        for (int k = 0; k < 6; k++) begin
            stall = (k % 2 == 1);
            tick();
            if (k % 2 == 0) begin
                checkOutput("tog_en", aluEn, 1);
                checkOutput("tog_a", aluA, 51 + k / 2);
                checkOutput("tog_res_idle", resValid, 0);
            end else begin
                checkOutput("tog_en_stalled", aluEn, 0);
                checkOutput("tog_res_valid", resValid, 1);
                checkOutput("tog_res_tag", resTag, 1 + k / 2);
            end
        end
        checkOutput("tog_count_end", count, 0);

        $display("[TB] reset with work in flight");
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 8'(60 + i), 8'd0, 3'd4, 4'(5 + i));
            tick();
        end
        applyStimulus(1'b0, 8'd0, 8'd0, 3'd0, 4'd0);
        stall = 1'b0;
        tick();
        checkOutput("pre_rst_en", aluEn, 1);
        checkOutput("pre_rst_count", count, 3);
        rstN = 1'b0;
        tick();
        rstN = 1'b1;
        checkOutput("mid_rst_count", count, 0);
        checkOutput("mid_rst_en", aluEn, 0);
        checkOutput("mid_rst_res_valid", resValid, 0);
        checkOutput("mid_rst_seen", illegalSeen, 0);
        checkOutput("mid_rst_cnt", illegalCnt, 0);
        checkOutput("mid_rst_ready", ifc.cmd_ready, 1);
        tick();
        checkOutput("post_rst_en", aluEn, 0);
        checkOutput("post_rst_res_valid", resValid, 0);
        checkOutput("post_rst_count", count, 0);
        tick();
        checkOutput("post_rst_res_valid2", resValid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
